matmul_seq_ctrl: RTL and testbench

Top-level sequencer for the UART matrix-multiply engine, running on the baud-derived clock (bclk).
- Parses the host byte stream: sync byte, then size N, then A elements, then B elements.
- Drives write enables and addresses into matrix memories A and B, then starts the Calculator and waits for done.
- Streams the 16-bit results back through uart_tx.
- Replaces the ad-hoc address counters and state decoding currently spread across top.

---
 rtl/matmul_pkg.sv | 27 ++
 rtl/tx_byte_sender.sv | 48 ++++
 rtl/matmul_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared definitions for the UART matrix-multiply sequencer.
//   state_t         : sequencer state encoding, also exported on the debug port
//   *_DEF           : default values for the sequencer parameters
//   RES_W           : width of one result element
//   elem_count()    : N*N for a latched matrix size
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RECV_SIZE = 3'd1,
    RECV_A    = 3'd2,
    RECV_B    = 3'd3,
    COMPUTE   = 3'd4,
    SEND      = 3'd5,
    SEND_WAIT = 3'd6
  } state_t;

  localparam int         MAX_N_DEF       = 3;
  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         CMP_TIMEOUT_DEF = 256;
  localparam int         RES_W           = 16;

  function automatic logic [7:0] elem_count(input logic [3:0] n);
    return {4'b0, n} * {4'b0, n};
  endfunction

endpackage

// File: rtl/tx_byte_sender.sv
// tx_byte_sender: start/busy handshake towards uart_tx.
//   clk, rst  : bclk domain clock, synchronous active-high reset
//   byte_data : byte to send when go is granted
//   go        : a byte is waiting to be sent
//   tx_busy   : uart_tx busy
//   tx_start  : one-cycle start pulse, only issued while tx_busy is low
//   tx_data   : byte to transmit, held from tx_start until the next start
//   done      : one-cycle strobe when uart_tx has finished the byte
module tx_byte_sender (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_data,
  input  logic       go,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  logic [7:0] data_q;
  logic       wait_q;
  logic       skip_q;

  // Start and data are combinational so the first byte can leave the cycle
  // right after the Calculator reports done; the byte is captured on start.
  assign tx_start = go & ~wait_q & ~tx_busy;
  assign tx_data  = tx_start ? byte_data : data_q;
  // uart_tx raises busy one cycle after start, so the cycle right after the
  // start pulse cannot be trusted as "finished".
  assign done     = wait_q & ~skip_q & ~tx_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      wait_q <= 1'b0;
      skip_q <= 1'b0;
    end else begin
      skip_q <= tx_start;
      if (tx_start) begin
        data_q <= byte_data;
        wait_q <= 1'b1;
      end else if (done) begin
        wait_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: host-stream sequencer for the UART matrix-multiply engine.
// Parses sync / size / A / B bytes, writes the A and B memories, starts the
// Calculator, then returns the 16-bit results LSB first through uart_tx.
//   clk, rst          : bclk clock, synchronous active-high reset
//   rx_data, rx_valid : byte stream from uart_rx
//   tx_busy           : uart_tx busy
//   mult_done         : Calculator finished strobe
//   res_data          : result element at res_addr
//   a_we, b_we        : matrix memory write strobes
//   mem_addr, wr_data : element address / data for those writes
//   mult_start        : Calculator start pulse
//   res_addr          : result element being sent
//   tx_start, tx_data : uart_tx start pulse / byte
//   matrix_size       : latched N
//   state             : current state (debug)
//   err               : sticky error (bad size or Calculator timeout)
// Build option: define MATMUL_CKSUM_EN to append an XOR checksum byte after
// the results.
//
// state     | meaning
// IDLE      | waiting for the sync byte
// RECV_SIZE | waiting for N
// RECV_A    | writing N*N elements of A
// RECV_B    | writing N*N elements of B
// COMPUTE   | Calculator running, timeout counter active
// SEND      | waiting for uart_tx to accept the next byte
// SEND_WAIT | byte in flight, waiting for uart_tx to go idle
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int         MAX_N       = MAX_N_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         CMP_TIMEOUT = CMP_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             tx_busy,
  input  logic             mult_done,
  input  logic [RES_W-1:0] res_data,
  output logic             a_we,
  output logic             b_we,
  output logic [3:0]       mem_addr,
  output logic [7:0]       wr_data,
  output logic             mult_start,
  output logic [3:0]       res_addr,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  output logic [3:0]       matrix_size,
  output logic [2:0]       state,
  output logic             err
);

  localparam int CYC_W = $clog2(CMP_TIMEOUT + 1);

  state_t           st;
  logic [3:0]       cnt;
  logic [CYC_W-1:0] cyc;
  logic             byte_sel;
  logic [7:0]       nn;
  logic             last_elem;
  logic             last_res;
  logic [7:0]       res_byte;
  logic [7:0]       sender_byte;
  logic             go;
  logic             snd_done;

  assign nn        = elem_count(matrix_size);
  assign last_elem = ({4'b0, cnt} == nn - 8'd1);
  assign last_res  = byte_sel && ({4'b0, res_addr} == nn - 8'd1);
  assign res_byte  = byte_sel ? res_data[RES_W-1:8] : res_data[7:0];
  assign go        = (st == SEND);
  assign state     = st;

`ifdef MATMUL_CKSUM_EN
  logic [7:0] cksum;
  logic       cks_phase;
  assign sender_byte = cks_phase ? cksum : res_byte;
`else
  assign sender_byte = res_byte;
`endif

  tx_byte_sender u_sender (
    .clk       (clk),
    .rst       (rst),
    .byte_data (sender_byte),
    .go        (go),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .done      (snd_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      cnt         <= '0;
      cyc         <= '0;
      byte_sel    <= 1'b0;
      a_we        <= 1'b0;
      b_we        <= 1'b0;
      mem_addr    <= '0;
      wr_data     <= '0;
      mult_start  <= 1'b0;
      res_addr    <= '0;
      matrix_size <= '0;
      err         <= 1'b0;
`ifdef MATMUL_CKSUM_EN
      cksum       <= '0;
      cks_phase   <= 1'b0;
`endif
    end else begin
      a_we       <= 1'b0;
      b_we       <= 1'b0;
      mult_start <= 1'b0;
      case (st)
        IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            err <= 1'b0;
            st  <= RECV_SIZE;
          end
        end
        RECV_SIZE: begin
          if (rx_valid) begin
            if (rx_data >= 8'd1 && rx_data <= 8'(MAX_N)) begin
              matrix_size <= rx_data[3:0];
              cnt         <= '0;
              st          <= RECV_A;
            end else begin
              err <= 1'b1;
              st  <= IDLE;
            end
          end
        end
        RECV_A, RECV_B: begin
          if (rx_valid) begin
            a_we     <= (st == RECV_A);
            b_we     <= (st == RECV_B);
            wr_data  <= rx_data;
            mem_addr <= cnt;
            if (last_elem) begin
              cnt <= '0;
              if (st == RECV_A) begin
                st <= RECV_B;
              end else begin
                st         <= COMPUTE;
                mult_start <= 1'b1;
                cyc        <= '0;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        COMPUTE: begin
          // done is checked first so it wins over a coincident timeout
          if (mult_done) begin
            st       <= SEND;
            res_addr <= '0;
            byte_sel <= 1'b0;
`ifdef MATMUL_CKSUM_EN
            cksum     <= '0;
            cks_phase <= 1'b0;
`endif
          end else if (cyc == CYC_W'(CMP_TIMEOUT - 1)) begin
            err <= 1'b1;
            st  <= IDLE;
          end else begin
            cyc <= cyc + CYC_W'(1);
          end
        end
        SEND: begin
          if (tx_start) begin
            st <= SEND_WAIT;
`ifdef MATMUL_CKSUM_EN
            if (!cks_phase) cksum <= cksum ^ tx_data;
`endif
          end
        end
        SEND_WAIT: begin
          if (snd_done) begin
`ifdef MATMUL_CKSUM_EN
            if (cks_phase) begin
              st <= IDLE;
            end else begin
              byte_sel <= ~byte_sel;
              if (byte_sel) res_addr <= res_addr + 4'd1;
              if (last_res) cks_phase <= 1'b1;
              st <= SEND;
            end
`else
            byte_sel <= ~byte_sel;
            if (byte_sel) res_addr <= res_addr + 4'd1;
            st <= last_res ? IDLE : SEND;
`endif
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
module tb_matmul_seq_ctrl;

  localparam int S_IDLE      = 0;
  localparam int S_RECV_SIZE = 1;
  localparam int S_RECV_B    = 3;
  localparam int S_SEND_WAIT = 6;
  localparam int TIMEOUT     = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_busy;
  logic        mult_done;
  logic [15:0] res_data;
  logic        a_we, b_we, mult_start, tx_start, err;
  logic [3:0]  mem_addr, res_addr, matrix_size;
  logic [7:0]  wr_data, tx_data;
  logic [2:0]  state;
  logic [35:0] outs;

  matmul_seq_ctrl dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .mult_done(mult_done), .res_data(res_data),
    .a_we(a_we), .b_we(b_we), .mem_addr(mem_addr), .wr_data(wr_data),
    .mult_start(mult_start), .res_addr(res_addr), .tx_start(tx_start),
    .tx_data(tx_data), .matrix_size(matrix_size), .state(state), .err(err)
  );

  assign outs = {a_we, b_we, mem_addr, wr_data, mult_start, res_addr,
                 tx_start, tx_data, matrix_size, state, err};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // host-side frame contents
  logic [7:0] av[9];
  logic [7:0] bv[9];
  logic [3:0] cur_n = 4'd1;
  int done_delay = 0;
  int busy_len = 0;

  // environment: matrix memories written by the DUT, Calculator result read
  logic [7:0] mem_a[16];
  logic [7:0] mem_b[16];
  always @(posedge clk) begin
    if (a_we) mem_a[mem_addr] <= wr_data;
    if (b_we) mem_b[mem_addr] <= wr_data;
  end

  logic [3:0] rr, cc;
  always_comb begin
    res_data = '0;
    rr = res_addr / cur_n;
    cc = res_addr % cur_n;
    for (int k = 0; k < 3; k++)
      if (4'(k) < cur_n)
        res_data = res_data + 16'(mem_a[4'(rr * cur_n + 4'(k))]) * 16'(mem_b[4'(4'(k) * cur_n + cc)]);
  end

  // Calculator done strobe done_delay cycles after mult_start (0 = never)
  int done_cnt;
  always @(posedge clk) begin
    if (rst) begin
      mult_done <= 1'b0;
      done_cnt  <= 0;
    end else begin
      mult_done <= 1'b0;
      if (mult_start && done_delay > 0) begin
        if (done_delay == 1) mult_done <= 1'b1;
        done_cnt <= done_delay - 1;
      end else if (done_cnt > 0) begin
        done_cnt <= done_cnt - 1;
        if (done_cnt == 1) mult_done <= 1'b1;
      end
    end
  end

  // uart_tx: busy rises the cycle after start and lasts busy_len cycles
  int busy_cnt;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // observation queues
  logic [11:0] a_q[$];
  logic [11:0] b_q[$];
  logic [7:0]  tx_q[$];
  int ms_cnt, ms_cyc, done_cyc, first_tx_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_we) a_q.push_back({mem_addr, wr_data});
      if (b_we) b_q.push_back({mem_addr, wr_data});
      if (mult_start) begin ms_cnt++; ms_cyc = cyc; end
      if (mult_done) done_cyc = cyc;
      if (tx_start) begin
        tx_q.push_back(tx_data);
        if (first_tx_cyc < 0) first_tx_cyc = cyc;
        checks++;
        assert (tx_busy === 1'b0) else begin
          errors++;
          $error("FAIL tx_start_while_busy: observed busy=%0b required 0", tx_busy);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int budget, output int at_cyc, output bit ok);
    ok = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(state) == st) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic send_frame_bytes(input int n);
    send_byte(8'hA5);
    send_byte(8'(n));
    for (int i = 0; i < n * n; i++) send_byte(av[i]);
    for (int i = 0; i < n * n; i++) send_byte(bv[i]);
  endtask

  task automatic run_frame(input int n, input int ddelay, input int blen, input bit inject, input string tag);
    int nn, idle_cyc, acc;
    bit ok;
    logic [7:0] exp_tx[$];
`ifdef MATMUL_CKSUM_EN
    logic [7:0] x;
    x = '0;
`endif
    nn = n * n;
    a_q.delete(); b_q.delete(); tx_q.delete();
    ms_cnt = 0; ms_cyc = -1; done_cyc = -1; first_tx_cyc = -1;
    cur_n = 4'(n); done_delay = ddelay; busy_len = blen;
    send_frame_bytes(n);
    if (inject) begin
      repeat (2) @(negedge clk);
      send_byte(8'hA5);
    end
    wait_state(S_IDLE, 5000, idle_cyc, ok);
    check({tag, " back_to_idle"}, 64'(ok), 64'(1));
    check({tag, " a_we_count"}, 64'(a_q.size()), 64'(nn));
    check({tag, " b_we_count"}, 64'(b_q.size()), 64'(nn));
    for (int i = 0; i < nn; i++) begin
      if (i < a_q.size()) check({tag, " a_write"}, 64'(a_q[i]), 64'({4'(i), av[i]}));
      if (i < b_q.size()) check({tag, " b_write"}, 64'(b_q[i]), 64'({4'(i), bv[i]}));
    end
    check({tag, " mult_start_count"}, 64'(ms_cnt), 64'(1));
    if (ddelay > 0) begin
      for (int i = 0; i < nn; i++) begin
        acc = 0;
        for (int k = 0; k < n; k++)
          acc += int'(av[(i / n) * n + k]) * int'(bv[k * n + (i % n)]);
        exp_tx.push_back(acc[7:0]);
        exp_tx.push_back(acc[15:8]);
`ifdef MATMUL_CKSUM_EN
        x = x ^ acc[7:0] ^ acc[15:8];
`endif
      end
`ifdef MATMUL_CKSUM_EN
      exp_tx.push_back(x);
`endif
      check({tag, " tx_count"}, 64'(tx_q.size()), 64'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size(); i++)
        if (i < tx_q.size()) check({tag, " tx_byte"}, 64'(tx_q[i]), 64'(exp_tx[i]));
      check({tag, " err"}, 64'(err), 64'(0));
      check({tag, " first_tx_latency"}, 64'(first_tx_cyc - done_cyc), 64'(1));
    end else begin
      check({tag, " err"}, 64'(err), 64'(1));
      check({tag, " tx_count"}, 64'(tx_q.size()), 64'(0));
      check({tag, " timeout_cycles"}, 64'(idle_cyc - ms_cyc), 64'(TIMEOUT));
    end
  endtask

  task automatic bad_size(input logic [7:0] sz, input string tag);
    a_q.delete();
    send_byte(8'hA5);
    check({tag, " sync_clears_err"}, 64'(err), 64'(0));
    check({tag, " state_recv_size"}, 64'(state), 64'(S_RECV_SIZE));
    send_byte(sz);
    @(negedge clk);
    check({tag, " err"}, 64'(err), 64'(1));
    check({tag, " state_idle"}, 64'(state), 64'(S_IDLE));
    check({tag, " no_a_we"}, 64'(a_q.size()), 64'(0));
  endtask

  task automatic rst_check(input string tag);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({tag, " outputs_zero"}, 64'(outs), 64'(0));
    rst = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] plan_tx[8];
    int at;
    bit ok;
    int n;

    repeat (3) @(negedge clk);
    check("reset outputs_zero", 64'(outs), 64'(0));
    rst = 1'b0;

    // directed frame from the test plan
    for (int i = 0; i < 4; i++) begin
      av[i] = 8'(i + 1);
      bv[i] = 8'(i + 5);
    end
    run_frame(2, 10, 3, 1'b1, "plan");
    plan_tx = '{8'h13, 8'h00, 8'h16, 8'h00, 8'h2B, 8'h00, 8'h32, 8'h00};
    for (int i = 0; i < 8; i++)
      if (i < tx_q.size()) check("plan literal_tx", 64'(tx_q[i]), 64'(plan_tx[i]));

    bad_size(8'h00, "size0");
    bad_size(8'h04, "size4");

    av[0] = 8'($urandom); bv[0] = 8'($urandom);
    run_frame(1, 0, 2, 1'b0, "timeout");

    for (int i = 0; i < 4; i++) begin av[i] = 8'($urandom); bv[i] = 8'($urandom); end
    run_frame(2, TIMEOUT - 1, 2, 1'b0, "done_at_limit");

    for (int i = 0; i < 9; i++) begin av[i] = 8'($urandom); bv[i] = 8'($urandom); end
    run_frame(3, 20, 40, 1'b1, "busy40");

    av[0] = 8'h14; bv[0] = 8'hE9;
    run_frame(1, 12, 4, 1'b0, "n1_0x1234");
    if (tx_q.size() > 1) begin
      check("n1_0x1234 lsb", 64'(tx_q[0]), 64'(8'h34));
      check("n1_0x1234 msb", 64'(tx_q[1]), 64'(8'h12));
    end
`ifdef MATMUL_CKSUM_EN
    if (tx_q.size() > 2) check("n1_0x1234 cksum", 64'(tx_q[2]), 64'(8'h26));
`endif

    // reset while receiving B
    cur_n = 4'd2;
    send_byte(8'hA5); send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    for (int i = 0; i < 2; i++) send_byte(8'($urandom));
    check("mid_recv_b state", 64'(state), 64'(S_RECV_B));
    rst_check("mid_recv_b");

    // reset while a result byte is in flight
    for (int i = 0; i < 4; i++) begin av[i] = 8'($urandom); bv[i] = 8'($urandom); end
    done_delay = 5; busy_len = 40;
    send_frame_bytes(2);
    wait_state(S_SEND_WAIT, 500, at, ok);
    check("mid_send reached", 64'(ok), 64'(1));
    rst_check("mid_send");

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < 9; i++) begin av[i] = 8'($urandom); bv[i] = 8'($urandom); end
      if (f == 0) begin
        av[0] = 8'hA5;
        bv[n * n - 1] = 8'hA5;
      end
      run_frame(n, $urandom_range(10, 60), $urandom_range(0, 6), 1'b1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
